// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Memory, decode handshake and redirect signals of the fetch unit
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
  logic [63:0] address;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        br_taken;
  logic [63:0] br_target;
  logic        fault;

  modport master (
    output address,
    input  instruction,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  br_taken,
    input  br_target,
    output fault
  );

  modport slave (
    input  address,
    output instruction,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output br_taken,
    output br_target,
    input  fault
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC-driven fetch from zero-latency memory into a 2-entry buffer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic clk,
  input  logic reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  // One extra bit so PC + 3 cannot wrap near the top of the address space
  localparam logic [64:0] c_mem_size = 65'(MEM_SIZE);

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_pc;
  logic [63:0] w_pc_next;
  logic [1:0]  r_count;
  logic [1:0]  w_count_next;
  logic        r_wr_ptr;
  logic        w_wr_ptr_next;
  logic        r_rd_ptr;
  logic        w_rd_ptr_next;
  logic [63:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];

  logic w_pop;
  logic w_push;
  logic w_room;
  logic w_illegal;

  assign w_illegal = (r_pc[1:0] != 2'b00) ||
                     (({1'b0, r_pc} + 65'd3) >= c_mem_size);
  assign w_pop     = (r_count != 2'd0) && bus.out_ready;
  assign w_room    = (r_count != 2'd2) || w_pop;

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_count_next  = r_count;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_push        = 1'b0;

    if (bus.br_taken) begin
      // Redirect wins over everything; any same-cycle pop is simply absorbed by the flush
      w_state_next  = S_RUN;
      w_pc_next     = bus.br_target;
      w_count_next  = 2'd0;
      w_wr_ptr_next = 1'b0;
      w_rd_ptr_next = 1'b0;
    end else begin
      if (w_pop) begin
        w_rd_ptr_next = ~r_rd_ptr;
      end
      if ((r_state == S_RUN) && w_room) begin
        if (w_illegal) begin
          w_state_next = S_FAULT;
        end else begin
          w_push        = 1'b1;
          w_pc_next     = r_pc + 64'd4;
          w_wr_ptr_next = ~r_wr_ptr;
        end
      end
      w_count_next = r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_count  <= w_count_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
    end
  end

  // Payload storage needs no reset: it is only observed while out_valid is high
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_pc;
      r_fifo_instr[r_wr_ptr] <= bus.instruction;
    end
  end

  assign bus.address   = r_pc;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_pc    = r_fifo_pc[r_rd_ptr];
  assign bus.out_instr = r_fifo_instr[r_rd_ptr];
  assign bus.fault     = (r_state == S_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit; memory word i holds i
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .MEM_SIZE (1024),
    .RESET_PC (64'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instruction = bus.address[33:2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.br_taken  = 1'b0;
    bus.br_target = 64'd0;

    #2;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    check("rst_addr", bus.address, 64'd0);
    step();
    step();
    reset = 1'b0;

    // Streaming
    for (int i = 0; i < 6; i++) begin
      step();
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_pc", bus.out_pc, 64'(4 * i));
      check("stream_instr", 64'(bus.out_instr), 64'(i));
    end

    // Async reset between edges mid-stream
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", 64'(bus.out_valid), 64'd0);
    check("areset_fault", 64'(bus.fault), 64'd0);
    check("areset_addr", bus.address, 64'd0);
    bus.out_ready = 1'b0;
    step();
    reset = 1'b0;

    // Stall with decode not ready
    step();
    check("stall1_pc", bus.out_pc, 64'd0);
    check("stall1_addr", bus.address, 64'd4);
    step();
    check("stall2_addr", bus.address, 64'd8);
    step();
    step();
    step();
    check("stall5_valid", 64'(bus.out_valid), 64'd1);
    check("stall5_pc", bus.out_pc, 64'd0);
    check("stall5_addr", bus.address, 64'd8);
    bus.out_ready = 1'b1;
    step();
    check("release_pc4", bus.out_pc, 64'd4);
    step();
    check("release_pc8", bus.out_pc, 64'd8);
    check("release_instr8", 64'(bus.out_instr), 64'd2);
    step();
    check("release_pc12", bus.out_pc, 64'd12);

    // Fill both entries, then redirect
    bus.out_ready = 1'b0;
    step();
    step();
    check("full_addr", bus.address, 64'd20);
    check("full_head", bus.out_pc, 64'd12);
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h40;
    step();
    bus.br_taken  = 1'b0;
    check("redir_valid", 64'(bus.out_valid), 64'd0);
    check("redir_addr", bus.address, 64'h40);
    bus.out_ready = 1'b1;
    step();
    check("redir_pc40", bus.out_pc, 64'h40);
    check("redir_instr40", 64'(bus.out_instr), 64'h10);
    step();
    check("redir_pc44", bus.out_pc, 64'h44);

    // Misaligned redirect faults on the first attempt, then recovery
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h6;
    step();
    bus.br_taken  = 1'b0;
    check("mis_fault0", 64'(bus.fault), 64'd0);
    check("mis_addr", bus.address, 64'h6);
    step();
    check("mis_fault1", 64'(bus.fault), 64'd1);
    check("mis_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("mis_hold_fault", 64'(bus.fault), 64'd1);
    check("mis_hold_addr", bus.address, 64'h6);
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h10;
    step();
    bus.br_taken  = 1'b0;
    check("recover_fault", 64'(bus.fault), 64'd0);
    check("recover_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("recover_valid1", 64'(bus.out_valid), 64'd1);
    check("recover_pc", bus.out_pc, 64'h10);
    check("recover_instr", 64'(bus.out_instr), 64'd4);

    // Stream to the end of memory
    bus.br_taken  = 1'b1;
    bus.br_target = 64'd0;
    step();
    bus.br_taken  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step();
      check("end_pc", bus.out_pc, 64'(4 * i));
      check("end_instr", 64'(bus.out_instr), 64'(i));
    end
    check("end_fault0", 64'(bus.fault), 64'd0);
    check("end_addr", bus.address, 64'h400);
    step();
    check("end_fault1", 64'(bus.fault), 64'd1);
    check("end_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("end_nopush", 64'(bus.out_valid), 64'd0);
    check("end_hold_addr", bus.address, 64'h400);
    check("end_hold_fault", 64'(bus.fault), 64'd1);

    // Async reset clears a fault immediately, fetch resumes after release
    #2;
    reset = 1'b1;
    #1;
    check("freset_fault", 64'(bus.fault), 64'd0);
    check("freset_valid", 64'(bus.out_valid), 64'd0);
    check("freset_addr", bus.address, 64'd0);
    step();
    reset = 1'b0;
    step();
    check("resume_valid", 64'(bus.out_valid), 64'd1);
    check("resume_pc", bus.out_pc, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, meaning instruction memory size in bytes (power of two, >4).
REQ-002 SHALL have parameter RESET_PC, default 64'd0, meaning fetch address loaded on reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port address, output, 64, byte address driven to the combinational instruction memory.
REQ-006 SHALL have port instruction, input, 32, word returned by memory for address in the same cycle.
REQ-007 SHALL have port out_valid, output, 1, buffer head holds a fetched instruction.
REQ-008 SHALL have port out_ready, input, 1, decode accepts the head this cycle.
REQ-009 SHALL have port out_instr, output, 32, head instruction word.
REQ-010 SHALL have port out_pc, output, 64, byte address of head instruction.
REQ-011 SHALL have port br_taken, input, 1, redirect request this cycle.
REQ-012 SHALL have port br_target, input, 64, redirect byte address.
REQ-013 SHALL have port fault, output, 1, fetch halted on illegal address.

Function
REQ-014 SHALL hold a 64-bit PC register and drive address = PC combinationally at all times.
REQ-015 SHALL contain a 2-entry FIFO of {pc, instr} pairs; out_valid = (count != 0); out_instr/out_pc = head entry.
REQ-016 SHALL complete a pop on a cycle where out_valid && out_ready.
REQ-017 SHALL, in state RUN with no redirect and a legal PC, push {PC, instruction} and set PC <= PC + 4 when count < 2, or count == 2 with a pop the same cycle.
REQ-018 SHALL not push and SHALL hold PC when count == 2 and no pop occurs (stall).
REQ-019 SHALL treat PC as illegal when PC[1:0] != 0 or PC + 3 >= MEM_SIZE.
REQ-020 SHALL, on a fetch attempt with an illegal PC in RUN, push nothing, enter FAULT and set fault = 1 at the next edge.
REQ-021 SHALL have exactly two states: RUN and FAULT; FAULT pushes nothing and leaves PC unchanged, but the FIFO continues to drain via pops.
REQ-022 SHALL, on br_taken in either state, flush the FIFO (count <= 0), set PC <= br_target, push nothing, clear fault and enter RUN; a pop handshake in the same cycle counts as consumed.
REQ-023 SHALL give br_taken priority over push, stall and fault detection in the same cycle.
REQ-024 SHALL fetch with zero-cycle memory latency: an instruction pushed at edge N is visible on out_instr after edge N.
REQ-025 SHALL keep the FIFO pointers modulo 2 and count within 0..2 under simultaneous push and pop.
REQ-026 SHALL let an illegal br_target fault on the first fetch attempt after the redirect.

Reset
REQ-027 SHALL, while reset = 1 and independent of clk, force PC = RESET_PC, count = 0, out_valid = 0, fault = 0, state = RUN.
REQ-028 SHALL keep out_instr/out_pc as don't-care while out_valid = 0.
REQ-029 SHALL, when reset asserts mid-operation, discard all buffered entries and the pending redirect.
REQ-030 SHALL resume fetching at RESET_PC on the first posedge clk after reset deasserts.

Verification
REQ-031 SHALL verify streaming: memory word i = i, out_ready = 1 -> out_pc = 0,4,8,... with out_instr = 0,1,2,... on consecutive cycles, starting one cycle after reset release.
REQ-032 SHALL verify stall: out_ready = 0 for 5 cycles -> count saturates at 2 (pc 0,4 held), address stays 8, and releasing yields 0,4,8 in order with no loss or duplication.
REQ-033 SHALL verify redirect: br_taken = 1, br_target = 0x40 while 2 entries are buffered -> out_valid = 0 next cycle, then out_pc = 0x40, 0x44.
REQ-034 SHALL verify fault: streaming with MEM_SIZE = 1024 -> last pushed out_pc = 0x3FC, fault = 1 when PC = 0x400, and no further pushes.
REQ-035 SHALL verify fault recovery and misalignment: br_target = 0x6 -> fault; then br_target = 0x10 -> fault = 0, out_pc = 0x10.
REQ-036 SHALL verify async reset: assert reset between clock edges mid-stream -> out_valid = 0 and fault = 0 immediately, address = RESET_PC.
